// File: rtl/shift_counter_gen.sv
`default_nettype none
// ============================================================================
// Module      : shift_counter_gen
// Description : Parametrised shift-register counter. At run time it can work
//               as a ring counter (one-hot phases) or as a Johnson
//               (twisted-ring) counter (thermometer phases). It has direction
//               control, a count enable, parallel load and a registered wrap
//               pulse. Illegal-state detection with self-recovery is
//               optional.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro:
//   SHIFT_CNT_SELFCORRECT_EN
//     defined   : illegal_o flags a state that is not legal for the current
//                 mode. An enabled, non-load edge in an illegal state
//                 reloads the start value.
//     undefined : illegal_o is tied to 0 and no legality logic is built.
// ----------------------------------------------------------------------------
// Parameters:
//   WIDTH       number of state bits (>= 2)
// Ports:
//   clk         clock, rising edge
//   rstn        synchronous active-low reset
//   en_i        count enable (one step per cycle)
//   mode_i      0 = ring, 1 = Johnson
//   dir_i       0 = shift toward LSB, 1 = shift toward MSB
//   load_i      parallel load strobe (takes priority over en_i)
//   load_val_i  value loaded into the state register
//   out_o       registered counter state
//   wrap_o      registered one-cycle pulse when a shift lands on the start
//   illegal_o   combinational illegal-state flag (0 when the macro is not set)
// ============================================================================
module shift_counter_gen #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en_i,
    input  logic             mode_i,
    input  logic             dir_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] out_o,
    output logic             wrap_o,
    output logic             illegal_o
);

    // Start value: only the LSB set. It is legal in both modes.
    localparam logic [WIDTH-1:0] C_S0 = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;
    logic             wrap_q;
    logic             wrap_d;

    logic [WIDTH-1:0] w_shift;
    logic             w_feedback;
    logic             w_illegal;

    // ------------------------------------------------------------------------
    // Shift step. The bit that wraps around is the end bit leaving the
    // register. Johnson mode inverts it, ring mode passes it through
    // unchanged. Because the mode bit works as an XOR, one datapath serves
    // both counter types.
    // ------------------------------------------------------------------------
    always_comb begin
        w_feedback = 1'b0;
        w_shift    = out_q;
        if (dir_i) begin
            w_feedback = out_q[WIDTH-1] ^ mode_i;
            w_shift    = {out_q[WIDTH-2:0], w_feedback};
        end else begin
            w_feedback = out_q[0] ^ mode_i;
            w_shift    = {w_feedback, out_q[WIDTH-1:1]};
        end
    end

    // ------------------------------------------------------------------------
    // Legality check (optional).
    //   Ring    : exactly one bit set.
    //   Johnson : at most one boundary between neighbouring bits. This means
    //             the register holds a block of ones at one end and zeros at
    //             the other (all-zero and all-one included).
    // ------------------------------------------------------------------------
`ifdef SHIFT_CNT_SELFCORRECT_EN
    logic [WIDTH-2:0] w_edges;

    always_comb begin
        w_edges = out_q[WIDTH-2:0] ^ out_q[WIDTH-1:1];
        if (mode_i) begin
            w_illegal = ($countones(w_edges) > 1);
        end else begin
            w_illegal = ($countones(out_q) != 1);
        end
    end
`else
    assign w_illegal = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Next state. Priority: load, recovery, shift, hold. Reset is applied in
    // the register process. wrap only fires for a true shift step that lands
    // on the start value, so load and recovery never cause a pulse.
    // ------------------------------------------------------------------------
    always_comb begin
        out_d  = out_q;
        wrap_d = 1'b0;
        if (load_i) begin
            out_d = load_val_i;
        end else if (en_i && w_illegal) begin
            // This branch can only be taken when the legality logic exists.
            // The shift is suppressed for this cycle.
            out_d = C_S0;
        end else if (en_i) begin
            out_d  = w_shift;
            wrap_d = (w_shift == C_S0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_q  <= C_S0;
            wrap_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            wrap_q <= wrap_d;
        end
    end

    assign out_o     = out_q;
    assign wrap_o    = wrap_q;
    assign illegal_o = w_illegal;

endmodule
`default_nettype wire

// File: tb/tb_shift_counter_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_counter_gen
// Description : Self-checking bench for shift_counter_gen (WIDTH = 4).
//               Directed sequences come first, then randomized stimulus.
//               A behavioural model is compared against the DUT on every
//               falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_counter_gen;

    localparam int W = 4;
    localparam logic [W-1:0] C_S0 = 4'b0001;

    logic         clk = 1'b0;
    logic         rstn;
    logic         en;
    logic         mode;
    logic         dir;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] out_w;
    logic         wrap_w;
    logic         illegal_w;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    shift_counter_gen #(.WIDTH(W)) u_dut (
        .clk        (clk),
        .rstn       (rstn),
        .en_i       (en),
        .mode_i     (mode),
        .dir_i      (dir),
        .load_i     (load),
        .load_val_i (load_val),
        .out_o      (out_w),
        .wrap_o     (wrap_w),
        .illegal_o  (illegal_w)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Reference model. A shift is modelled as a rotate by one place. Johnson
    // mode flips the bit that wraps around. Legality is tested arithmetically:
    //   ring    -> a power of two
    //   Johnson -> v+1 or (~v)+1 is a power of two (a run of ones at one end)
    // ------------------------------------------------------------------------
    logic [W-1:0] m_out;
    logic         m_wrap;

    function automatic bit is_pow2(input int unsigned x);
        return (x != 0) && ((x & (x - 1)) == 0);
    endfunction

    function automatic bit m_legal(input logic [W-1:0] v, input logic md);
        int unsigned iv;
        int unsigned inv;
        iv  = int'(v);
        inv = int'(~v) & ((1 << W) - 1);
        if (md) return is_pow2(iv + 1) || is_pow2(inv + 1);
        return is_pow2(iv);
    endfunction

    function automatic logic [W-1:0] m_step(input logic [W-1:0] v,
                                            input logic md, input logic dr);
        int unsigned x;
        int unsigned b;
        x = int'(v);
        if (!dr) begin
            b = x & 1;
            if (md) b = b ^ 1;
            x = (x >> 1) | (b << (W - 1));
        end else begin
            b = (x >> (W - 1)) & 1;
            if (md) b = b ^ 1;
            x = ((x << 1) & ((1 << W) - 1)) | b;
        end
        return x[W-1:0];
    endfunction

    function automatic bit m_illegal(input logic [W-1:0] v, input logic md);
`ifdef SHIFT_CNT_SELFCORRECT_EN
        return !m_legal(v, md);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        if (!rstn) begin
            m_out  = C_S0;
            m_wrap = 1'b0;
        end else if (load) begin
            m_out  = load_val;
            m_wrap = 1'b0;
        end else if (en && m_illegal(m_out, mode)) begin
            m_out  = C_S0;
            m_wrap = 1'b0;
        end else if (en) begin
            m_out  = m_step(m_out, mode, dir);
            m_wrap = (m_out == C_S0);
        end else begin
            m_wrap = 1'b0;
        end
    end

    // Every-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            checks++;
            if (out_w !== m_out) begin
                errors++;
                $display("FAIL model_out t=%0t actual=%b required=%b", $time, out_w, m_out);
            end
            checks++;
            if (wrap_w !== m_wrap) begin
                errors++;
                $display("FAIL model_wrap t=%0t actual=%b required=%b", $time, wrap_w, m_wrap);
            end
            checks++;
            if (illegal_w !== m_illegal(m_out, mode)) begin
                errors++;
                $display("FAIL model_illegal t=%0t actual=%b required=%b", $time,
                         illegal_w, m_illegal(m_out, mode));
            end
        end
    end

    // ------------------------------------------------------------------------
    // Directed helpers
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic run_seq(input string name, input logic [W-1:0] seq [8], input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            chk($sformatf("%s_out%0d", name, k), out_w, seq[k]);
            chk($sformatf("%s_wrap%0d", name, k), {3'b000, wrap_w},
                {3'b000, (k == n - 1)});
        end
    endtask

    logic [W-1:0] seq_j0 [8];
    logic [W-1:0] seq_j1 [8];
    logic [W-1:0] seq_r0 [8];
    logic [W-1:0] seq_r1 [8];

    initial begin
        seq_j0 = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001};
        seq_j1 = '{4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0001};
        seq_r0 = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        seq_r1 = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};

        rstn = 1'b0; en = 1'b0; mode = 1'b1; dir = 1'b0; load = 1'b0; load_val = '0;
        tick();
        tick();
        chk_on = 1'b1;
        chk("reset_out", out_w, C_S0);
        chk("reset_wrap", {3'b000, wrap_w}, 4'b0000);
        chk("reset_illegal", {3'b000, illegal_w}, 4'b0000);
        rstn = 1'b1;

        // Johnson, both directions
        en = 1'b1; mode = 1'b1; dir = 1'b0;
        run_seq("j_dir0", seq_j0, 8);
        dir = 1'b1;
        run_seq("j_dir1", seq_j1, 8);

        // Ring, both directions (two periods toward LSB)
        mode = 1'b0; dir = 1'b0;
        run_seq("r_dir0a", seq_r0, 4);
        run_seq("r_dir0b", seq_r0, 4);
        dir = 1'b1;
        run_seq("r_dir1", seq_r1, 4);

        // Load beats enable, then hold
        mode = 1'b1; load = 1'b1; load_val = 4'b1100; en = 1'b1;
        tick();
        chk("load_out", out_w, 4'b1100);
        chk("load_wrap", {3'b000, wrap_w}, 4'b0000);
        load = 1'b0; en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("hold_out%0d", k), out_w, 4'b1100);
        end

        // Illegal states
        dir = 1'b0; load = 1'b1; load_val = 4'b0101;
        tick();
        load = 1'b0; en = 1'b1;
`ifdef SHIFT_CNT_SELFCORRECT_EN
        chk("j_illegal_flag", {3'b000, illegal_w}, 4'b0001);
        tick();
        chk("j_recover_out", out_w, 4'b0001);
        chk("j_recover_wrap", {3'b000, wrap_w}, 4'b0000);
`else
        chk("j_illegal_flag", {3'b000, illegal_w}, 4'b0000);
        tick();
        chk("j_noselfcorr_out", out_w, 4'b0010);
`endif
        mode = 1'b0; load = 1'b1; load_val = 4'b0000; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1;
`ifdef SHIFT_CNT_SELFCORRECT_EN
        chk("r_illegal_flag", {3'b000, illegal_w}, 4'b0001);
        tick();
        chk("r_recover_out", out_w, 4'b0001);
`else
        chk("r_illegal_flag", {3'b000, illegal_w}, 4'b0000);
        tick();
        chk("r_noselfcorr_out", out_w, 4'b0000);
`endif

        // Reset mid-run overrides load and enable
        rstn = 1'b0; tick(); rstn = 1'b1;
        mode = 1'b1; dir = 1'b0; en = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        chk("midrun_pre", out_w, 4'b1110);
        rstn = 1'b0; load = 1'b1; load_val = 4'b1010;
        tick();
        chk("midrun_rst_out", out_w, 4'b0001);
        chk("midrun_rst_wrap", {3'b000, wrap_w}, 4'b0000);
        rstn = 1'b1; load = 1'b0;
        tick();
        chk("midrun_resume", out_w, 4'b0000);

        // Randomized phase, checked by the model on every cycle
        for (int k = 0; k < 3000; k++) begin
            en   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            if ($urandom_range(0, 15) == 0) dir = ~dir;
            load     = ($urandom_range(0, 19) == 0);
            load_val = 4'($urandom_range(0, 15));
            rstn     = ($urandom_range(0, 99) != 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
